multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the MIPS CPU datapath.
- Sequences fetch, decode, execute, memory and write-back for each instruction.
- Drives the immediate-extension mode (ExtSel: sign vs zero) and the ALU, register-file, memory and PC controls.
- Sits between the instruction register (IR) and the datapath; waits on a memory-ready handshake.

Parameters:
- CNT_W, 32, width of the optional performance counters.
- HALT_OP, 6'b111111, opcode that stops the FSM.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- op  input  6  IR[31:26]; stable from ID until the next IF.
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag; sampled combinationally in EXE.
- mem_ready  input  1  data memory completes access this cycle.
- state  output  3  current state: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5.
- IRWre  output  1  load IR.
- PCWre  output  1  update PC this cycle.
- PCSrc  output  2  00 PC+4; 01 PC+4+(ext<<2); 10 jump target.
- ExtSel  output  1  1 sign-extend imm16; 0 zero-extend.
- ALUSrcB  output  1  1 extended immediate; 0 rt data.
- ALUOp  output  3  000 add, 001 sub, 010 and, 011 or.
- RegDst  output  1  1 rd; 0 rt.
- RegWre  output  1  register-file write enable.
- DBDataSrc  output  1  1 memory data; 0 ALU result to register file.
- MemRd  output  1  data-memory read strobe.
- MemWr  output  1  data-memory write strobe.

Behaviour:
- Decoded opcodes:
  - R-type 000000 with funct 100000 add, 100010 sub, 100100 and, 100101 or.
  - addi 001000, ori 001101, lw 100011, sw 101011, beq 000100, j 000010, HALT_OP.
- State is registered. Outputs are combinational from state, op, funct, zero and mem_ready.
- Any output not listed for a state is 0.
- All enables (IRWre, PCWre, RegWre, MemRd, MemWr) are forced to 0 while Reset=1.
- Reset: state<=IF next edge. Reset mid-operation (e.g. MEM) drops MemWr/MemRd in the same cycle; there is no partial write-back.
- IF: IRWre=1 -> ID.
- ID:
  - j: PCWre=1, PCSrc=10 -> IF.
  - HALT_OP -> HALT.
  - Unknown opcode, or R-type with unknown funct: PCWre=1, PCSrc=00 -> IF (nop).
  - All other opcodes -> EXE.
- EXE:
  - ExtSel=1 for addi/lw/sw/beq; 0 for ori.
  - ALUSrcB=1 for addi/ori/lw/sw.
  - ALUOp per funct for R-type; add for addi/lw/sw; or for ori; sub for beq.
  - beq: PCWre=1, PCSrc=zero?01:00 -> IF.
  - lw/sw -> MEM.
  - Others -> WB.
- ExtSel and ALU controls hold their EXE values through MEM and WB.
- MEM:
  - lw: MemRd=1. sw: MemWr=1.
  - Strobes stay asserted, and the FSM stays in MEM, while mem_ready=0. There is no timeout.
  - When mem_ready=1: sw -> PCWre=1, PCSrc=00 -> IF; lw -> WB.
- WB: RegWre=1, RegDst=1 for R-type, DBDataSrc=1 for lw; PCWre=1, PCSrc=00 -> IF.
- HALT: all enables 0; stays in HALT until Reset.
- Latency (cycles): j/nop 2; beq 3; R/addi/ori 4; sw 4+wait; lw 5+wait.
- PCWre is asserted exactly once per instruction, in its final cycle.
- mem_ready is ignored outside MEM.

Optional Feature:
- Macro CTRL_PERF_CNT_EN.
- When defined, adds two outputs:
  - cycle_cnt[CNT_W-1:0]: +1 every non-reset cycle with state!=HALT.
  - instr_cnt[CNT_W-1:0]: +1 on every cycle with PCWre=1.
  - Both reset to 0 synchronously and wrap modulo 2^CNT_W.
  - Both freeze in HALT.
- When undefined, the ports and logic are absent; the FSM is unchanged.

Test Plan:
- Reset=1 for 2 cycles, then release with op=000000 funct=100000 -> state IF,ID,EXE,WB; ALUOp=000 in EXE; RegWre=1, RegDst=1, PCWre=1 in WB; back to IF on cycle 5.
- ori (op=001101) -> ExtSel=0, ALUSrcB=1, ALUOp=011 in EXE; RegDst=0 in WB.
- lw with mem_ready low 3 cycles -> MemRd=1 for 4 MEM cycles, then WB with DBDataSrc=1; 8 cycles total.
- beq with zero=1 -> PCSrc=01, PCWre=1 in EXE; repeat with zero=0 -> PCSrc=00.
- sw in MEM with mem_ready=0, assert Reset -> MemWr=0 the same cycle, state=IF after edge. Then op=111111 -> HALT held 10 cycles with all enables 0.
- CTRL_PERF_CNT_EN: run j, addi, halt from reset -> instr_cnt=2, cycle_cnt=8 (IF ID | IF ID EXE WB | IF ID), then both frozen.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: IF/ID/EXE/MEM/WB sequencing with HALT; optional perf counters (CTRL_PERF_CNT_EN).
// Latency: j/nop 2, beq 3, R/addi/ori 4, sw 4+wait, lw 5+wait cycles; outputs are combinational from state.
// Backpressure: holds in MEM with strobes asserted while mem_ready=0 (no timeout); mem_ready ignored elsewhere.
module multicycle_ctrl #(
   parameter int         CNT_W   = 32,
   parameter logic [5:0] HALT_OP = 6'b111111
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic [5:0] op,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic [2:0] state,
   output logic       IRWre,
   output logic       PCWre,
   output logic [1:0] PCSrc,
   output logic       ExtSel,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       RegDst,
   output logic       RegWre,
   output logic       DBDataSrc,
   output logic       MemRd,
   output logic       MemWr
`ifdef CTRL_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic [CNT_W-1:0] instr_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EXE  = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_ORI  = 6'b001101;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;

   state_t state_q, state_d;

   logic       is_r, is_addi, is_ori, is_lw, is_sw, is_beq, is_j, is_halt;
   logic       r_ok, exe_ok;
   logic       ext_dec, srcb_dec;
   logic [2:0] alu_dec;

   // Instruction decode; op/funct are stable from ID through the last cycle of the instruction.
   always_comb begin
      is_r    = (op == OP_R);
      is_addi = (op == OP_ADDI);
      is_ori  = (op == OP_ORI);
      is_lw   = (op == OP_LW);
      is_sw   = (op == OP_SW);
      is_beq  = (op == OP_BEQ);
      is_j    = (op == OP_J);
      is_halt = (op == HALT_OP);
      r_ok    = 1'b1;
      alu_dec = ALU_ADD;
      if (is_r) begin
         case (funct)
            6'b100000: alu_dec = ALU_ADD;
            6'b100010: alu_dec = ALU_SUB;
            6'b100100: alu_dec = ALU_AND;
            6'b100101: alu_dec = ALU_OR;
            default:   r_ok    = 1'b0;
         endcase
      end else if (is_ori) begin
         alu_dec = ALU_OR;
      end else if (is_beq) begin
         alu_dec = ALU_SUB;
      end
      // Instructions that need an EXE cycle; anything else falls through as a nop.
      exe_ok   = (is_r && r_ok) || is_addi || is_ori || is_lw || is_sw || is_beq;
      ext_dec  = is_addi || is_lw || is_sw || is_beq;
      srcb_dec = is_addi || is_ori || is_lw || is_sw;
   end

   // Next-state and control outputs; reset forces all enables low and returns to IF.
   always_comb begin
      state_d   = state_q;
      IRWre     = 1'b0;
      PCWre     = 1'b0;
      PCSrc     = 2'b00;
      ExtSel    = 1'b0;
      ALUSrcB   = 1'b0;
      ALUOp     = ALU_ADD;
      RegDst    = 1'b0;
      RegWre    = 1'b0;
      DBDataSrc = 1'b0;
      MemRd     = 1'b0;
      MemWr     = 1'b0;
      case (state_q)
         S_IF: begin
            IRWre   = 1'b1;
            state_d = S_ID;
         end
         S_ID: begin
            if (is_j) begin
               PCWre   = 1'b1;
               PCSrc   = 2'b10;
               state_d = S_IF;
            end else if (is_halt) begin
               state_d = S_HALT;
            end else if (!exe_ok) begin
               PCWre   = 1'b1;
               state_d = S_IF;
            end else begin
               state_d = S_EXE;
            end
         end
         S_EXE: begin
            ExtSel  = ext_dec;
            ALUSrcB = srcb_dec;
            ALUOp   = alu_dec;
            if (is_beq) begin
               PCWre   = 1'b1;
               PCSrc   = zero ? 2'b01 : 2'b00;
               state_d = S_IF;
            end else if (is_lw || is_sw) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end
         S_MEM: begin
            ExtSel  = ext_dec;
            ALUSrcB = srcb_dec;
            ALUOp   = alu_dec;
            MemRd   = is_lw;
            MemWr   = is_sw;
            if (mem_ready) begin
               if (is_sw) begin
                  PCWre   = 1'b1;
                  state_d = S_IF;
               end else begin
                  state_d = S_WB;
               end
            end
         end
         S_WB: begin
            ExtSel    = ext_dec;
            ALUSrcB   = srcb_dec;
            ALUOp     = alu_dec;
            RegWre    = 1'b1;
            RegDst    = is_r;
            DBDataSrc = is_lw;
            PCWre     = 1'b1;
            state_d   = S_IF;
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IF;
      endcase
      if (Reset) begin
         IRWre   = 1'b0;
         PCWre   = 1'b0;
         RegWre  = 1'b0;
         MemRd   = 1'b0;
         MemWr   = 1'b0;
         state_d = S_IF;
      end
   end

   // State register.
   always_ff @(posedge CLK) begin
      state_q <= state_d;
   end

   assign state = state_q;

`ifdef CTRL_PERF_CNT_EN
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
   logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

   // Counters advance outside HALT only; PCWre marks each retired instruction.
   always_comb begin
      cycle_cnt_d = cycle_cnt_q;
      instr_cnt_d = instr_cnt_q;
      if (Reset) begin
         cycle_cnt_d = '0;
         instr_cnt_d = '0;
      end else begin
         if (state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
         if (PCWre)             instr_cnt_d = instr_cnt_q + CNT_W'(1);
      end
   end

   // Counter registers.
   always_ff @(posedge CLK) begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule
